// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, totals helpers and the control bundle type.
package vga_timing_pkg;

    // Default 640x480@60 mode
    localparam int unsigned H_DISP_DEF = 640;
    localparam int unsigned H_FP_DEF   = 16;
    localparam int unsigned H_SYNC_DEF = 96;
    localparam int unsigned H_BP_DEF   = 48;
    localparam int unsigned V_DISP_DEF = 480;
    localparam int unsigned V_FP_DEF   = 10;
    localparam int unsigned V_SYNC_DEF = 2;
    localparam int unsigned V_BP_DEF   = 33;

    localparam logic SYNC_ACT_LOW  = 1'b0;
    localparam logic SYNC_ACT_HIGH = 1'b1;

    typedef struct packed {
        logic hs;
        logic vs;
        logic visible;
        logic tick;
        logic frame_start;
        logic line_start;
    } ctrl_t;

    function automatic int unsigned h_total(input int unsigned disp, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return disp + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned disp, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return disp + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_pipe_if.sv
// Timing outputs from the generator to the sync pins and pixel pipeline.
interface vga_sync_pipe_if #(
    parameter int unsigned W = 10
);
    logic         oHS;
    logic         oVS;
    logic         visible;
    logic         p_tick;
    logic [W-1:0] pixel_x;
    logic [W-1:0] pixel_y;
    logic         frame_start;
    logic         line_start;

    modport master (
        output oHS, oVS, visible, p_tick, pixel_x, pixel_y, frame_start, line_start
    );

    modport slave (
        input oHS, oVS, visible, p_tick, pixel_x, pixel_y, frame_start, line_start
    );
endinterface

// File: rtl/vga_sync_pipe_delay_line.sv
// Resettable shift register; zero depth is a straight wire.
module delay_line #(
    parameter int unsigned       WIDTH     = 1,
    parameter int unsigned       DEPTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ reset;
        assign q = d;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage [DEPTH];

        // Shift one stage per clk; reset flushes every stage
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < int'(DEPTH); i++) stage[i] <= RESET_VAL;
            end else begin
                stage[0] <= d;
                for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[DEPTH-1];
    end
endmodule

// File: rtl/vga_sync_pipe.sv
// VGA timing generator with pixel-clock divider and latency-matching delay lines.
module vga_sync_pipe
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISP      = H_DISP_DEF,
    parameter int unsigned H_FP        = H_FP_DEF,
    parameter int unsigned H_SYNC      = H_SYNC_DEF,
    parameter int unsigned H_BP        = H_BP_DEF,
    parameter int unsigned V_DISP      = V_DISP_DEF,
    parameter int unsigned V_FP        = V_FP_DEF,
    parameter int unsigned V_SYNC      = V_SYNC_DEF,
    parameter int unsigned V_BP        = V_BP_DEF,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned CTRL_DELAY  = 5,
    parameter int unsigned COORD_DELAY = 1,
    parameter logic        HS_POL      = SYNC_ACT_LOW,
    parameter logic        VS_POL      = SYNC_ACT_LOW,
    parameter int unsigned W           = 10
) (
    input  logic            clk,
    input  logic            reset,
    vga_sync_pipe_if.master vga
);
    localparam int unsigned H_TOTAL  = h_total(H_DISP, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = v_total(V_DISP, V_FP, V_SYNC, V_BP);
    localparam int unsigned HS_START = H_DISP + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_DISP + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CTRL_W   = $bits(ctrl_t);
    localparam logic [CTRL_W-1:0] CTRL_RST = {~HS_POL, ~VS_POL, 4'b0000};

    logic [DIV_W-1:0] div_cnt;
    logic [W-1:0]     h_cnt;
    logic [W-1:0]     v_cnt;
    logic             tick_raw;
    ctrl_t            ctrl_raw;
    ctrl_t            ctrl_q;
    logic [2*W-1:0]   coord_q;

    // With CLK_DIV=1 the 1-bit divider stays at 0, so the tick is constantly high
    assign tick_raw = (div_cnt == DIV_W'(CLK_DIV - 1));

    // Pixel divider and raster counters
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            div_cnt <= tick_raw ? '0 : div_cnt + 1'b1;
            if (tick_raw) begin
                if (h_cnt == W'(H_TOTAL - 1)) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == W'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    // Raw control bundle decoded from the counters
    always_comb begin
        ctrl_raw             = ctrl_t'(CTRL_RST);
        ctrl_raw.hs          = (h_cnt >= W'(HS_START) && h_cnt < W'(HS_END)) ? HS_POL : ~HS_POL;
        ctrl_raw.vs          = (v_cnt >= W'(VS_START) && v_cnt < W'(VS_END)) ? VS_POL : ~VS_POL;
        ctrl_raw.visible     = (h_cnt < W'(H_DISP)) && (v_cnt < W'(V_DISP));
        ctrl_raw.tick        = tick_raw;
        ctrl_raw.line_start  = tick_raw && (h_cnt == '0);
        ctrl_raw.frame_start = tick_raw && (h_cnt == '0) && (v_cnt == '0);
    end

    delay_line #(
        .WIDTH     (CTRL_W),
        .DEPTH     (CTRL_DELAY),
        .RESET_VAL (CTRL_RST)
    ) u_ctrl_dly (
        .clk   (clk),
        .reset (reset),
        .d     (ctrl_raw),
        .q     (ctrl_q)
    );

    delay_line #(
        .WIDTH     (2 * W),
        .DEPTH     (COORD_DELAY),
        .RESET_VAL ('0)
    ) u_coord_dly (
        .clk   (clk),
        .reset (reset),
        .d     ({h_cnt, v_cnt}),
        .q     (coord_q)
    );

    assign vga.oHS         = ctrl_q.hs;
    assign vga.oVS         = ctrl_q.vs;
    assign vga.visible     = ctrl_q.visible;
    assign vga.p_tick      = ctrl_q.tick;
    assign vga.frame_start = ctrl_q.frame_start;
    assign vga.line_start  = ctrl_q.line_start;
    assign vga.pixel_x     = coord_q[2*W-1:W];
    assign vga.pixel_y     = coord_q[W-1:0];
endmodule

// File: tb/tb_vga_sync_pipe.sv
// Directed bench: default mode, minimal mode and a small mode for mid-frame reset.
module tb_vga_sync_pipe;
    logic clk = 1'b0;
    logic rst_def = 1'b1;
    logic rst_min = 1'b1;
    logic rst_mid = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vga_sync_pipe_if #(.W(10)) if_def ();
    vga_sync_pipe_if #(.W(4))  if_min ();
    vga_sync_pipe_if #(.W(5))  if_mid ();

    vga_sync_pipe u_def (
        .clk   (clk),
        .reset (rst_def),
        .vga   (if_def.master)
    );

    vga_sync_pipe #(
        .H_DISP(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_DISP(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .CTRL_DELAY(0), .COORD_DELAY(0), .W(4)
    ) u_min (
        .clk   (clk),
        .reset (rst_min),
        .vga   (if_min.master)
    );

    vga_sync_pipe #(
        .H_DISP(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(4), .CTRL_DELAY(5), .COORD_DELAY(1), .W(5)
    ) u_mid (
        .clk   (clk),
        .reset (rst_mid),
        .vga   (if_mid.master)
    );

    typedef struct {
        int         edge_n;
        logic [5:0] ctrl;   // {oHS, oVS, visible, p_tick, frame_start, line_start}
        int         x;
        int         y;
    } vec_t;

    vec_t tbl [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // which: 0 = default DUT, 1 = small-mode DUT
    task automatic snap(input int which, output logic [5:0] c, output int x, output int y);
        if (which == 0) begin
            c = {if_def.oHS, if_def.oVS, if_def.visible, if_def.p_tick,
                 if_def.frame_start, if_def.line_start};
            x = int'(if_def.pixel_x);
            y = int'(if_def.pixel_y);
        end else begin
            c = {if_mid.oHS, if_mid.oVS, if_mid.visible, if_mid.p_tick,
                 if_mid.frame_start, if_mid.line_start};
            x = int'(if_mid.pixel_x);
            y = int'(if_mid.pixel_y);
        end
    endtask

    task automatic run_startup(input int which);
        logic [5:0] c;
        int x, y;
        for (int i = 0; i < 13; i++) begin
            step();
            snap(which, c, x, y);
            check($sformatf("startup%0d edge%0d ctrl", which, tbl[i].edge_n), 64'(c), 64'(tbl[i].ctrl));
            check($sformatf("startup%0d edge%0d xy", which, tbl[i].edge_n),
                  {32'(x), 32'(y)}, {32'(tbl[i].x), 32'(tbl[i].y)});
        end
    endtask

    initial begin
        logic [5:0] c;
        int x, y;
        int h, v;
        bit found;
        logic prev_hs;
        int low_cnt, tick_cnt, vis_cnt, ls_cnt, vs_low;

        // Edges after reset release: p_tick/frame/line start first at edge 8, x=1 from edge 5
        for (int i = 0; i < 13; i++) begin
            tbl[i].edge_n = i + 1;
            tbl[i].y      = 0;
        end
        for (int i = 0; i < 4; i++)  begin tbl[i].ctrl = 6'b110000; tbl[i].x = 0; end
        for (int i = 4; i < 7; i++)  begin tbl[i].ctrl = 6'b111000; tbl[i].x = 1; end
        tbl[7].ctrl = 6'b111111; tbl[7].x = 1;
        for (int i = 8; i < 11; i++) begin tbl[i].ctrl = 6'b111000; tbl[i].x = 2; end
        tbl[11].ctrl = 6'b111100; tbl[11].x = 2;
        tbl[12].ctrl = 6'b111000; tbl[12].x = 3;

        // Reset held for 10 clks on the default DUT
        for (int i = 0; i < 10; i++) begin
            step();
            snap(0, c, x, y);
            check($sformatf("reset_hold%0d", i), {32'(c), 16'(x), 16'(y)}, {32'(6'b110000), 16'd0, 16'd0});
        end

        rst_def = 1'b0;
        run_startup(0);

        // One full oHS period of the default mode, measured from a falling edge
        found = 1'b0;
        prev_hs = if_def.oHS;
        for (int i = 0; i < 6000 && !found; i++) begin
            step();
            if (prev_hs && !if_def.oHS) found = 1'b1;
            prev_hs = if_def.oHS;
        end
        check("hs_fall_found", 64'(found), 64'(1));
        low_cnt = 0; tick_cnt = 0; vis_cnt = 0; ls_cnt = 0; vs_low = 0;
        for (int i = 0; i < 3200; i++) begin
            if (!if_def.oHS)       low_cnt++;
            if (if_def.p_tick)     tick_cnt++;
            if (if_def.visible)    vis_cnt++;
            if (if_def.line_start) ls_cnt++;
            if (!if_def.oVS)       vs_low++;
            prev_hs = if_def.oHS;
            step();
        end
        check("hs_low_clks", 64'(low_cnt), 64'(384));
        check("ticks_per_line", 64'(tick_cnt), 64'(800));
        check("visible_clks", 64'(vis_cnt), 64'(2560));
        check("line_starts", 64'(ls_cnt), 64'(1));
        check("vs_inactive", 64'(vs_low), 64'(0));
        check("hs_period_3200", {63'(0), prev_hs && !if_def.oHS}, 64'(1));

        // Minimal mode: combinational outputs track the counters directly
        step();
        rst_min = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            step();
            h = k % 7;
            v = (k / 7) % 5;
            check($sformatf("min_k%0d", k),
                  {56'({if_min.oHS, if_min.oVS, if_min.visible, if_min.p_tick,
                        if_min.frame_start, if_min.line_start}), if_min.pixel_x, if_min.pixel_y},
                  {56'({h != 5, v != 3, (h < 4) && (v < 2), 1'b1, (h == 0) && (v == 0), h == 0}),
                   4'(h), 4'(v)});
        end

        // Small mode: run into the frame, pulse reset for one clk, then startup must repeat
        rst_mid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            step();
            if (int'(if_mid.pixel_y) == 3 && int'(if_mid.pixel_x) == 5) found = 1'b1;
        end
        check("mid_position_found", 64'(found), 64'(1));
        rst_mid = 1'b1;
        step();
        snap(1, c, x, y);
        check("mid_reset_values", {32'(c), 16'(x), 16'(y)}, {32'(6'b110000), 16'd0, 16'd0});
        rst_mid = 1'b0;
        run_startup(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
